// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
//
// Multi-cycle multiply/divide unit that owns the architectural HI/LO registers.
// A radix-2 shift-add multiplier and a restoring divider share one 2*WIDTH
// accumulator. Operands are reduced to magnitudes at accept and the sign is
// applied once, in a single FIX cycle, before HI/LO are written. mthi/mtlo
// write HI/LO directly from IDLE.
//
// Ports:
//   clk     in   rising-edge clock
//   reset   in   synchronous, active-low reset
//   start   in   issue strobe from the E stage (one cycle per instruction)
//   op      in   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none
//   rs_val  in   operand A / dividend / mthi-mtlo source
//   rt_val  in   operand B / divisor
//   cancel  in   abort the in-flight operation (pipeline flush)
//   busy    out  operation in flight; pipeline stalls start and mfhi/mflo
//   done    out  one-cycle pulse in the cycle after a mult/div updates HI/LO
//   hi      out  HI register
//   lo      out  LO register
// -----------------------------------------------------------------------------
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  // Magnitude of a two's-complement operand; the most negative value maps to
  // itself, which is its correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic                    as_signed);
    logic [WIDTH-1:0] m;
    m = v;
    if (as_signed && v < 0) m = -v;
    return m;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                  input logic             neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] apply_sign_wide(input logic [2*WIDTH-1:0] v,
                                                         input logic               neg);
    return neg ? -v : v;
  endfunction

  // Control state
  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  // Datapath state. For mult: a_q = multiplicand magnitude, acc_q = {0, B}.
  // For div: a_q = raw dividend (div-by-zero HI), b_q = divisor magnitude,
  // acc_q = {remainder, dividend bits still to be shifted in / quotient}.
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               is_div_q, is_div_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic               div0_q, div0_d;

  logic               signed_op;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_trial;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fixed;

  // Shift-add step: add multiplicand into the upper half when the current
  // multiplier bit is set, then shift the whole accumulator right.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring step: the partial remainder can need WIDTH+1 bits after the
  // shift, so the trial subtraction is done one bit wider and its MSB is the
  // borrow that decides restore vs. keep.
  assign div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = div_trial - {1'b0, b_q};
  assign div_next  = div_diff[WIDTH] ? {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

  assign prod_fixed = apply_sign_wide(acc_q, neg_lo_q);
  assign signed_op  = (op == OP_MULT) || (op == OP_DIV);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    div0_d   = div0_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && !cancel) begin
          unique case (op)
            OP_MULT, OP_MULTU: begin
              a_d      = magnitude(rs_val, signed_op);
              acc_d    = {{WIDTH{1'b0}}, magnitude(rt_val, signed_op)};
              neg_lo_d = signed_op && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
              neg_hi_d = 1'b0;
              div0_d   = 1'b0;
              is_div_d = 1'b0;
              cnt_d    = '0;
              state_d  = S_MUL;
            end
            OP_DIV, OP_DIVU: begin
              a_d      = rs_val;
              b_d      = magnitude(rt_val, signed_op);
              acc_d    = {{WIDTH{1'b0}}, magnitude(rs_val, signed_op)};
              neg_lo_d = signed_op && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
              neg_hi_d = signed_op && rs_val[WIDTH-1];
              div0_d   = (rt_val == '0);
              is_div_d = 1'b1;
              cnt_d    = '0;
              state_d  = S_DIV;
            end
            OP_MTHI: hi_d = rs_val;
            OP_MTLO: lo_d = rs_val;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        acc_d = mul_next;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DIV: begin
        acc_d = div_next;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (!is_div_q) begin
          hi_d = prod_fixed[2*WIDTH-1:WIDTH];
          lo_d = prod_fixed[WIDTH-1:0];
        end else if (div0_q) begin
          hi_d = a_q;
          lo_d = {WIDTH{1'b1}};
        end else begin
          hi_d = apply_sign(acc_q[2*WIDTH-1:WIDTH], neg_hi_q);
          lo_d = apply_sign(acc_q[WIDTH-1:0], neg_lo_q);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A flush abandons the operation, including one already in FIX.
    if (cancel && state_q != S_IDLE) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_ff @(posedge clk) begin
    a_q      <= a_d;
    b_q      <= b_d;
    acc_q    <= acc_d;
    is_div_q <= is_div_d;
    neg_lo_q <= neg_lo_d;
    neg_hi_q <= neg_hi_d;
    div0_q   <= div0_d;
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] rs_val;
  logic [W-1:0] rt_val;
  logic         cancel;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  always #5 clk = ~clk;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .cancel (cancel),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] rs;
    logic [W-1:0] rt;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
  } vec_t;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } res_t;

  vec_t vecs[11];
  res_t expq[$];
  int   compared   = 0;
  int   mismatched = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: each done pulse retires the oldest expected result.
  always @(negedge clk) begin
    res_t r;
    if (reset === 1'b1 && done === 1'b1) begin
      if (expq.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_done: got done=1 expected no pending result");
      end else begin
        r = expq.pop_front();
        check("result_hi", 64'(hi), 64'(r.hi));
        check("result_lo", 64'(lo), 64'(r.lo));
      end
    end
  end

  task automatic expect_result(input logic [W-1:0] h, input logic [W-1:0] l);
    res_t r;
    r.hi = h;
    r.lo = l;
    expq.push_back(r);
  endtask

  // Accept edge falls between the two negedges; returns in cycle 1.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    @(negedge clk);
    start = 1'b0;
    op    = 3'd0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    expect_result(v.exp_hi, v.exp_lo);
    issue(v.op, v.rs, v.rt);
    wait_idle(n);
    check("busy_cycles", 64'(n), 64'd33);
    check("done_pulse", 64'(done), 64'd1);
    @(negedge clk);
    check("done_clear", 64'(done), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset  = 1'b0;
    start  = 1'b0;
    cancel = 1'b0;
    op     = 3'd0;
    rs_val = '0;
    rt_val = '0;

    //            op    rs            rt            exp_hi        exp_lo
    vecs[0]  = '{3'd2, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
    vecs[1]  = '{3'd1, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[2]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[3]  = '{3'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4]  = '{3'd4, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
    vecs[5]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[6]  = '{3'd3, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[7]  = '{3'd4, 32'd100,      32'd7,        32'd2,        32'd14};
    vecs[8]  = '{3'd1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2};
    vecs[9]  = '{3'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[10] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};

    // Reset held for two cycles.
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 11; i++) run_vec(vecs[i]);

    // mthi / mtlo from IDLE.
    @(negedge clk);
    start = 1'b1; op = 3'd5; rs_val = 32'h0000AAAA;
    @(negedge clk);
    start = 1'b0; op = 3'd0;
    check("mthi_hi", 64'(hi), 64'h0000AAAA);
    check("mthi_busy", 64'(busy), 64'd0);
    @(negedge clk);
    start = 1'b1; op = 3'd6; rs_val = 32'h00001234;
    @(negedge clk);
    start = 1'b0; op = 3'd0;
    check("mtlo_lo", 64'(lo), 64'h00001234);
    check("mtlo_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("mtlo_no_done", 64'(done), 64'd0);

    // mthi issued while a divu is busy is dropped.
    expect_result(32'd2, 32'd14);
    issue(3'd4, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    start = 1'b1; op = 3'd5; rs_val = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0; op = 3'd0;
    check("mthi_busy_hi", 64'(hi), 64'h0000AAAA);
    wait_idle(n);
    check("mthi_busy_cycles", 64'(n), 64'd29);
    check("mthi_busy_done", 64'(done), 64'd1);

    // Preload HI/LO, then cancel a mult at cycle 10.
    @(negedge clk);
    start = 1'b1; op = 3'd5; rs_val = 32'h0000AAAA;
    @(negedge clk);
    op = 3'd6; rs_val = 32'h00005555;
    @(negedge clk);
    start = 1'b0; op = 3'd0;
    check("preload_hi", 64'(hi), 64'h0000AAAA);
    check("preload_lo", 64'(lo), 64'h00005555);
    issue(3'd1, 32'd3, 32'd5);
    repeat (9) @(negedge clk);
    check("cancel_pre_busy", 64'(busy), 64'd1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_busy", 64'(busy), 64'd0);
    check("cancel_hi", 64'(hi), 64'h0000AAAA);
    check("cancel_lo", 64'(lo), 64'h00005555);
    repeat (40) @(negedge clk);
    check("cancel_hold_lo", 64'(lo), 64'h00005555);

    // Cancel while in FIX (cycle 33).
    issue(3'd1, 32'd3, 32'd5);
    repeat (32) @(negedge clk);
    check("fix_pre_busy", 64'(busy), 64'd1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("fixcancel_busy", 64'(busy), 64'd0);
    check("fixcancel_done", 64'(done), 64'd0);
    check("fixcancel_hi", 64'(hi), 64'h0000AAAA);
    check("fixcancel_lo", 64'(lo), 64'h00005555);

    // start + cancel together in IDLE: mthi dropped.
    @(negedge clk);
    start = 1'b1; op = 3'd5; rs_val = 32'h0000BEEF; cancel = 1'b1;
    @(negedge clk);
    start = 1'b0; op = 3'd0; cancel = 1'b0;
    check("startcancel_hi", 64'(hi), 64'h0000AAAA);
    check("startcancel_busy", 64'(busy), 64'd0);

    // Reset during a divu at cycle 20.
    issue(3'd4, 32'd1000, 32'd3);
    repeat (19) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_hi", 64'(hi), 64'd0);
    check("midrst_lo", 64'(lo), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    reset = 1'b1;
    run_vec('{3'd2, 32'd3, 32'd4, 32'd0, 32'd12});

    repeat (3) @(negedge clk);
    check("queue_empty", 64'(expq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers, driven from the E stage by the decoder's multiply control.
- Sequences a radix-2 iterative multiplier and restoring divider, handles signed pre/post fix-up, and exports `busy` so the hazard logic stalls dependent or overlapping instructions.
- Also services mthi/mtlo writes and exposes HI/LO for mfhi/mflo.

Parameters:
- WIDTH, 32, operand width; the iteration count equals WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  issue strobe from E stage, one cycle per instruction.
- op  in  3  0=none, 1=mult, 2=multu, 3=div, 4=divu, 5=mthi, 6=mtlo, 7=reserved (treated as none).
- rs_val  in  WIDTH  operand A / dividend / mthi-mtlo source.
- rt_val  in  WIDTH  operand B / divisor.
- cancel  in  1  abort the in-flight operation (pipeline flush).
- busy  out  1  operation in flight; the pipeline must stall any start and any mfhi/mflo while high.
- done  out  1  one-cycle pulse in the cycle after HI/LO are updated by mult or div.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE, hi=0, lo=0, busy=0, done=0, iteration counter=0.
  - Reset overrides start, cancel and any in-flight operation.
- States and busy:
  - States: IDLE, MUL, DIV, FIX.
  - busy = (state != IDLE), registered. done is registered.
- Accept (IDLE, start=1, cancel=0):
  - mult/multu: latch |A| and |B| (magnitudes for mult, raw for multu). Record result sign = A[31]^B[31] (mult only). Clear the accumulator. count=0. Go to MUL.
  - div/divu: latch magnitudes the same way. Record quotient sign = A[31]^B[31] and remainder sign = A[31] (div only). Record div0 = (rt_val==0). Go to DIV.
  - mthi/mtlo: hi or lo <= rs_val at that edge. Stay IDLE. busy stays 0. No done.
  - op none/reserved: ignored.
- MUL:
  - One shift-add step per cycle over a 2*WIDTH accumulator.
  - After WIDTH steps (count==WIDTH-1 at the edge), go to FIX.
- DIV:
  - One restoring step per cycle: shift remainder left, subtract divisor, keep the result if non-negative and set the quotient bit.
  - After WIDTH steps, go to FIX.
- FIX (one cycle), registered at its closing edge:
  - mult: {hi,lo} <= signed 64-bit product, negated if the sign bit is set. multu: raw product.
  - div: lo <= quotient (negated if quotient sign), hi <= remainder (negated if remainder sign).
  - div0 (div or divu): lo <= all ones, hi <= rs_val as latched at accept. No negation.
  - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. This falls out of the magnitude path; no special case.
  - Transition to IDLE. done=1 in the following cycle.
- Latency:
  - Accept edge at cycle 0; busy high for cycles 1..WIDTH+1 (33 cycles).
  - HI/LO valid and busy low in cycle WIDTH+2 (34); done high in the same cycle.
- Boundaries:
  - start while busy: ignored, including mthi/mtlo. Preventing this is the pipeline's job.
  - cancel while busy: return to IDLE at the next edge. HI/LO unchanged, no done.
  - cancel in FIX: cancel wins, HI/LO unchanged.
  - cancel and start together in IDLE: cancel wins, op dropped (mthi/mtlo included).
  - hi/lo change only at the FIX closing edge, an mthi/mtlo edge, or reset. They never show partial results.
  - The counter must not wrap. FIX is entered exactly once per operation.

Test Plan:
- Reset low for 2 cycles, then multu rs=0xFFFFFFFF rt=2 -> busy high for 33 cycles; cycle 34: hi=0x00000001, lo=0xFFFFFFFE, done=1 for one cycle.
- mult rs=0xFFFFFFFD (-3) rt=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then mult 0x80000000 by 0x80000000 -> hi=0x40000000, lo=0.
- div rs=0xFFFFFFF9 (-7) rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 7/0 -> lo=0xFFFFFFFF, hi=7. div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- mtlo rs=0x1234 in IDLE -> lo=0x1234 next cycle, busy stays 0. mthi issued while a divu is busy -> hi unaffected; divu result stands.
- Start mult with hi=0xAAAA, lo=0x5555 preloaded, assert cancel at cycle 10 -> busy low at cycle 11, hi/lo unchanged, no done. start+cancel together in IDLE with mthi -> hi unchanged.
- Drive reset low at cycle 20 of a divu -> next cycle busy=0, hi=lo=0, done=0. A new multu 3*4 issued afterwards -> lo=12, hi=0 after 33 busy cycles.
